// File: rtl/fetch_stage.sv
// PC generation, single-outstanding instruction fetch and the IF/ID pipeline register.
// Fetched words are delivered straight to IF/ID, or parked in hold_q while decode is blocked.
module fetch_stage #(
    parameter int unsigned       DWIDTH   = 32,
    parameter int unsigned       AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000,
    parameter logic [DWIDTH-1:0] NOP      = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_if,
    input  logic              ifid_wren,
    input  logic              ifid_flush,
    input  logic              redirect_valid,
    input  logic [AWIDTH-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [AWIDTH-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DWIDTH-1:0] imem_rsp_data,
    output logic [AWIDTH-1:0] f_pc,
    output logic [DWIDTH-1:0] f_insn,
    output logic [AWIDTH-1:0] d_pc,
    output logic [DWIDTH-1:0] d_insn,
    output logic              d_valid,
    output logic              fetch_misaligned
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] pc_q, pc_d;
    logic              stale_q, stale_d;
    logic [DWIDTH-1:0] hold_q, hold_d;
    logic [AWIDTH-1:0] d_pc_q, d_pc_d;
    logic [DWIDTH-1:0] d_insn_q, d_insn_d;
    logic              d_valid_q, d_valid_d;
    logic              mis_q, mis_d;

    logic              deliver_ok;
    logic              deliver;
    logic [DWIDTH-1:0] deliver_word;

    assign deliver_ok = ifid_wren & ~stall_if & ~ifid_flush;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        stale_d      = stale_q;
        hold_d       = hold_q;
        d_pc_d       = d_pc_q;
        d_insn_d     = d_insn_q;
        d_valid_d    = d_valid_q;
        mis_d        = 1'b0;
        deliver      = 1'b0;
        deliver_word = hold_q;

        if (redirect_valid) begin
            pc_d   = {redirect_pc[AWIDTH-1:2], 2'b00};
            mis_d  = |redirect_pc[1:0];
            hold_d = NOP;
            // A word still in flight belongs to the old path: mark it so it is dropped on arrival.
            if (state_q == S_WAIT && !imem_rsp_valid) begin
                stale_d = 1'b1;
            end else begin
                state_d = S_REQ;
                stale_d = 1'b0;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_req_ready) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (stale_q) begin
                            stale_d = 1'b0;
                            state_d = S_REQ;
                        end else if (deliver_ok) begin
                            deliver      = 1'b1;
                            deliver_word = imem_rsp_data;
                            state_d      = S_REQ;
                        end else begin
                            hold_d  = imem_rsp_data;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (deliver_ok) begin
                        deliver      = 1'b1;
                        deliver_word = hold_q;
                        state_d      = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end

        if (deliver) pc_d = pc_q + AWIDTH'(4);

        if (ifid_flush) begin
            d_insn_d  = NOP;
            d_valid_d = 1'b0;
        end else if (deliver) begin
            d_pc_d    = pc_q;
            d_insn_d  = deliver_word;
            d_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_REQ;
            pc_q      <= BASEADDR;
            stale_q   <= 1'b0;
            hold_q    <= NOP;
            d_pc_q    <= BASEADDR;
            d_insn_q  <= NOP;
            d_valid_q <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            stale_q   <= stale_d;
            hold_q    <= hold_d;
            d_pc_q    <= d_pc_d;
            d_insn_q  <= d_insn_d;
            d_valid_q <= d_valid_d;
            mis_q     <= mis_d;
        end
    end

    // Only a fresh, non-stale response or the parked word is visible to the hazard unit.
    always_comb begin
        f_insn = NOP;
        case (state_q)
            S_WAIT:  if (imem_rsp_valid && !stale_q) f_insn = imem_rsp_data;
            S_HOLD:  f_insn = hold_q;
            default: f_insn = NOP;
        endcase
    end

    assign imem_req_valid   = rst_n & (state_q == S_REQ);
    assign imem_req_addr    = pc_q;
    assign f_pc             = pc_q;
    assign d_pc             = d_pc_q;
    assign d_insn           = d_insn_q;
    assign d_valid          = d_valid_q;
    assign fetch_misaligned = mis_q;

endmodule
